// File: rtl/riscv_dmem_bus_if.sv
// riscv_dmem_bus_if: memory-stage req/gnt/rvalid data bus interface with stall, misalign and timeout reporting
module riscv_dmem_bus_if #(
  parameter int MP_ADDR_WIDTH = 32,
  parameter int MP_DATA_WIDTH = 32,
  parameter int MP_BIG_ENDIAN = 1,
  parameter int MP_TIMEOUT    = 64
) (
  input  logic                     iclk,
  input  logic                     irst,
  input  logic                     ird_en,
  input  logic                     iwr_en,
  input  logic [MP_ADDR_WIDTH-1:0] iaddr,
  input  logic [MP_DATA_WIDTH-1:0] iwr_data,
  input  logic [1:0]               isize,
  output logic [MP_DATA_WIDTH-1:0] ord_data,
  output logic                     ostall,
  output logic                     oerr_misalign,
  output logic                     oerr_timeout,
  output logic                     obus_req,
  output logic                     obus_we,
  output logic [MP_ADDR_WIDTH-1:0] obus_addr,
  output logic [3:0]               obus_be,
  output logic [MP_DATA_WIDTH-1:0] obus_wdata,
  input  logic                     ibus_gnt,
  input  logic                     ibus_rvalid,
  input  logic [MP_DATA_WIDTH-1:0] ibus_rdata
);
  localparam int CW = MP_TIMEOUT > 0 ? $clog2(MP_TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, REQ, RDATA, DONE} state_t;
  state_t                   r_state;
  logic [CW-1:0]            r_cnt;
  logic [MP_DATA_WIDTH-1:0] r_rdata;
  logic                     w_acc;
  logic                     w_mis;
  logic                     w_to;
  logic [3:0]               w_be;
  logic [MP_DATA_WIDTH-1:0] w_wdata;
  assign w_acc = ird_en | iwr_en;
  assign w_mis = (isize == 2'b11) | (isize == 2'b10 & iaddr[1:0] != 2'b00) | (isize == 2'b01 & iaddr[0]);
  // the abort cycle itself already drops the request, so the bus never sees a grant race with the timeout
  assign w_to = (MP_TIMEOUT != 0) && (r_state == REQ || r_state == RDATA) && r_cnt == CW'(MP_TIMEOUT);
  // byte-lane enables and lane-replicated store data from size, offset and endianness
  always_comb begin
    w_be = isize == 2'b10 ? 4'b1111 :
           isize == 2'b01 ? (MP_BIG_ENDIAN != 0 ? 4'b1100 >> {iaddr[1], 1'b0} : 4'b0011 << {iaddr[1], 1'b0}) :
                            (MP_BIG_ENDIAN != 0 ? 4'b1000 >> iaddr[1:0] : 4'b0001 << iaddr[1:0]);
    w_wdata = isize == 2'b00 ? {4{iwr_data[7:0]}} : isize == 2'b01 ? {2{iwr_data[15:0]}} : iwr_data;
  end
  assign obus_req      = r_state == REQ && !w_to;
  assign obus_we       = obus_req & iwr_en;
  assign obus_addr     = obus_req ? {iaddr[MP_ADDR_WIDTH-1:2], 2'b00} : '0;
  assign obus_be       = obus_req ? w_be : 4'b0000;
  assign obus_wdata    = obus_we ? w_wdata : '0;
  assign ostall        = (r_state == IDLE && w_acc && !w_mis) || r_state == REQ || r_state == RDATA;
  assign oerr_misalign = r_state == IDLE && w_acc && w_mis;
  assign oerr_timeout  = w_to;
  assign ord_data      = r_rdata;
  // transaction sequencer: issue once, wait for grant and read data, release the pipeline for one cycle
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      r_cnt <= r_state == IDLE ? '0 : r_cnt + 1'b1;
      case (r_state)
        IDLE: r_state <= w_acc && !w_mis ? REQ : IDLE;
        REQ: begin
          if (w_to) begin
            r_rdata <= '0;
            r_state <= DONE;
          end else if (ibus_gnt) begin
            if (iwr_en) r_state <= DONE;
            else if (ibus_rvalid) begin
              r_rdata <= ibus_rdata;
              r_state <= DONE;
            end else r_state <= RDATA;
          end
        end
        RDATA: begin
          if (w_to) begin
            r_rdata <= '0;
            r_state <= DONE;
          end else if (ibus_rvalid) begin
            r_rdata <= ibus_rdata;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_dmem_bus_if.sv
// tb_riscv_dmem_bus_if: randomized bench for little- and big-endian instances against a lane/cycle model
module tb_riscv_dmem_bus_if;
  localparam int TO = 8;
  logic        iclk = 1'b0;
  logic        irst;
  logic        ird_en;
  logic        iwr_en;
  logic [31:0] iaddr;
  logic [31:0] iwr_data;
  logic [1:0]  isize;
  logic        ibus_gnt;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;
  logic [31:0] ord_data [2];
  logic        ostall [2];
  logic        oerr_misalign [2];
  logic        oerr_timeout [2];
  logic        obus_req [2];
  logic        obus_we [2];
  logic [31:0] obus_addr [2];
  logic [3:0]  obus_be [2];
  logic [31:0] obus_wdata [2];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_rd = '0;
  always #5 iclk = ~iclk;
  for (genvar e = 0; e < 2; e++) begin : g_dut
    riscv_dmem_bus_if #(.MP_ADDR_WIDTH(32), .MP_DATA_WIDTH(32), .MP_BIG_ENDIAN(e), .MP_TIMEOUT(TO)) dut (
      .iclk(iclk), .irst(irst), .ird_en(ird_en), .iwr_en(iwr_en), .iaddr(iaddr), .iwr_data(iwr_data),
      .isize(isize), .ord_data(ord_data[e]), .ostall(ostall[e]), .oerr_misalign(oerr_misalign[e]),
      .oerr_timeout(oerr_timeout[e]), .obus_req(obus_req[e]), .obus_we(obus_we[e]), .obus_addr(obus_addr[e]),
      .obus_be(obus_be[e]), .obus_wdata(obus_wdata[e]), .ibus_gnt(ibus_gnt), .ibus_rvalid(ibus_rvalid),
      .ibus_rdata(ibus_rdata)
    );
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] exp_be(input int big, input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] b = 4'b0000;
    for (int k = int'(off); k < int'(off) + (1 << sz); k++) b[big != 0 ? 3 - k : k] = 1'b1;
    return b;
  endfunction
  function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    int n = 1 << sz;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction
  // one access: g = cycles of REQ before grant, r = cycles from grant to rvalid
  task automatic run_txn(input bit rd, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                         input int g, input int r);
    bit mis = sz == 2'b11 || (sz == 2'b10 && a[1:0] != 2'b00) || (sz == 2'b01 && a[0]);
    int t = rd ? g + 1 + r : g + 1;
    bit to = !mis && t > TO;
    int e_stall = mis ? 0 : (to ? TO + 2 : 1 + t);
    int e_req = mis ? 0 : (g + 1 < TO ? g + 1 : TO);
    int stall [2] = '{0, 0};
    int reqc [2] = '{0, 0};
    int misc [2] = '{0, 0};
    int toc [2] = '{0, 0};
    bit done = 1'b0;
    ird_en = rd;
    iwr_en = !rd;
    iaddr = a;
    isize = sz;
    iwr_data = rd ? $urandom : d;
    for (int c = 0; c < 16 && !done; c++) begin
      ibus_gnt = c == 1 + g || (c == 0 && $urandom_range(1) == 1);
      ibus_rvalid = (rd && c == 1 + g + r) || (c == 0 && $urandom_range(1) == 1);
      ibus_rdata = rd && c == 1 + g + r ? d : $urandom;
      @(negedge iclk);
      for (int e = 0; e < 2; e++) begin
        stall[e] += int'(ostall[e]);
        misc[e] += int'(oerr_misalign[e]);
        toc[e] += int'(oerr_timeout[e]);
        if (obus_req[e]) begin
          reqc[e]++;
          chk("addr", obus_addr[e], {a[31:2], 2'b00});
          chk(e != 0 ? "be_big" : "be_little", {28'd0, obus_be[e]}, {28'd0, exp_be(e, sz, a[1:0])});
          chk("we", {31'd0, obus_we[e]}, {31'd0, !rd});
          if (!rd) chk("wdata", obus_wdata[e], exp_wd(sz, d));
        end
      end
      done = !ostall[0];
      @(posedge iclk);
      #1;
    end
    chk("terminated", {31'd0, done}, 32'd1);
    if (!mis && rd) m_rd = to ? 32'd0 : d;
    for (int e = 0; e < 2; e++) begin
      chk("stall_cycles", stall[e], e_stall);
      chk("req_cycles", reqc[e], e_req);
      chk("misalign_pulses", misc[e], {31'd0, mis});
      chk("timeout_pulses", toc[e], {31'd0, to});
      chk("rd_data", ord_data[e], m_rd);
    end
    ibus_gnt = 1'b0;
    ibus_rvalid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    irst = 1'b1;
    {ird_en, iwr_en, ibus_gnt, ibus_rvalid} = '0;
    iaddr = '0;
    iwr_data = '0;
    isize = '0;
    ibus_rdata = '0;
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    for (int e = 0; e < 2; e++) begin
      chk("rst_rd_data", ord_data[e], 32'd0);
      chk("rst_stall_req", {30'd0, ostall[e], obus_req[e]}, 32'd0);
      chk("rst_err", {30'd0, oerr_misalign[e], oerr_timeout[e]}, 32'd0);
    end
    @(posedge iclk);
    #1;
    irst = 1'b0;
    run_txn(1'b1, 2'b10, 32'h100, 32'hDEADBEEF, 0, 2);
    run_txn(1'b0, 2'b00, 32'h203, 32'h000000A5, 0, 0);
    run_txn(1'b1, 2'b01, 32'h102, 32'h12345678, 3, 0);
    run_txn(1'b0, 2'b10, 32'h101, 32'hCAFEF00D, 0, 0);
    run_txn(1'b1, 2'b11, 32'h100, 32'h11111111, 0, 0);
    run_txn(1'b1, 2'b10, 32'h300, 32'h55AA55AA, 20, 0);
    run_txn(1'b1, 2'b10, 32'h304, 32'h77777777, 0, 0);
    run_txn(1'b1, 2'b10, 32'h308, 32'h99999999, 2, 7);
    run_txn(1'b1, 2'b10, 32'h40C, 32'hA1B2C3D4, 0, 0);
    // reset while waiting for read data, then a response that must be ignored
    ird_en = 1'b1;
    iwr_en = 1'b0;
    iaddr = 32'h40;
    isize = 2'b10;
    @(posedge iclk);
    #1;
    ibus_gnt = 1'b1;
    @(posedge iclk);
    #1;
    ibus_gnt = 1'b0;
    irst = 1'b1;
    @(posedge iclk);
    #1;
    irst = 1'b0;
    ird_en = 1'b0;
    ibus_rvalid = 1'b1;
    ibus_rdata = 32'hBAD0BAD0;
    @(negedge iclk);
    for (int e = 0; e < 2; e++) begin
      chk("rst_mid_req", {31'd0, obus_req[e]}, 32'd0);
      chk("rst_mid_stall", {31'd0, ostall[e]}, 32'd0);
      chk("rst_mid_rd_data", ord_data[e], 32'd0);
      chk("rst_mid_err", {30'd0, oerr_misalign[e], oerr_timeout[e]}, 32'd0);
    end
    @(posedge iclk);
    #1;
    ibus_rvalid = 1'b0;
    @(negedge iclk);
    for (int e = 0; e < 2; e++) chk("rst_late_rvalid", ord_data[e], 32'd0);
    @(posedge iclk);
    #1;
    m_rd = '0;
    for (int i = 0; i < 80; i++) begin
      bit rd = $urandom_range(1) == 1;
      logic [1:0] sz = $urandom_range(9) == 0 ? 2'b11 : 2'($urandom_range(2));
      int g = $urandom_range(7) == 0 ? int'($urandom_range(10, 6)) : int'($urandom_range(3));
      int r = $urandom_range(7) == 0 ? int'($urandom_range(9, 5)) : int'($urandom_range(3));
      run_txn(rd, sz, $urandom, $urandom, g, r);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
